robot_gait_sequencer: RTL

Upstream pose sequencer for the biped hip joints. It steps through a fixed 8-entry gait table and drives target angles to the left and right hip speed-ramp stages. Each ramp stage moves its servo angle one degree at a time and raises a done flag when it reaches the target. The sequencer waits until both done flags are high, dwells, then issues the next pose; it also handles start/stop, walking direction, amplitude scaling, return-to-home and a stall timeout.

---
 rtl/robot_gait_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/robot_gait_sequencer.sv
// Biped hip gait sequencer: walks an 8-pose table, scales each pose by amplitude,
// and hands targets to the ramp stages, with dwell, stop/home and stall timeout.
module robot_gait_sequencer #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int DWELL_CYCLES   = 2_500_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iStop,
  input  logic       iDir,
  input  logic [1:0] iAmp,
  input  logic [1:0] iDone,
  output logic [7:0] oHipL,
  output logic [7:0] oHipR,
  output logic [2:0] oPoseIdx,
  output logic       oBusy,
  output logic       oStepPulse,
  output logic       oFault
);

  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  HOME_DEG   = 8'd90;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLDOFF = 3'd1,
    S_WAIT    = 3'd2,
    S_DWELL   = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hipl_q, hipl_d;
  logic [7:0]  hipr_q, hipr_d;
  logic        stop_q, stop_d;
  logic        homing_q, homing_d;
  logic        step_q, step_d;
  logic [2:0]  nxt_idx;
  logic        busy;

  function automatic logic [7:0] gait_l(input logic [2:0] idx);
    case (idx)
      3'd0: gait_l = 8'd90;
      3'd1: gait_l = 8'd105;
      3'd2: gait_l = 8'd120;
      3'd3: gait_l = 8'd105;
      3'd4: gait_l = 8'd90;
      3'd5: gait_l = 8'd75;
      3'd6: gait_l = 8'd60;
      default: gait_l = 8'd75;
    endcase
  endfunction

  // Right hip mirrors the left about 90 degrees.
  function automatic logic [7:0] gait_r(input logic [2:0] idx);
    gait_r = 8'd180 - gait_l(idx);
  endfunction

  function automatic logic [7:0] sat_angle(input logic signed [11:0] val);
    if (val < 12'sd0)
      sat_angle = 8'd0;
    else if (val > 12'sd180)
      sat_angle = 8'd180;
    else
      sat_angle = val[7:0];
  endfunction

  // Deviation from 90 is scaled by (amp+1)/2, floored via arithmetic shift.
  function automatic logic [7:0] scale_angle(input logic [7:0] base, input logic [1:0] amp);
    logic signed [11:0] dev;
    logic signed [11:0] mult;
    logic signed [11:0] prod;
    dev  = $signed({4'b0000, base}) - 12'sd90;
    mult = $signed({10'b0, amp}) + 12'sd1;
    prod = dev * mult;
    scale_angle = sat_angle((prod >>> 1) + 12'sd90);
  endfunction

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hipl_q   <= HOME_DEG;
      hipr_q   <= HOME_DEG;
      stop_q   <= 1'b0;
      homing_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hipl_q   <= hipl_d;
      hipr_q   <= hipr_d;
      stop_q   <= stop_d;
      homing_q <= homing_d;
      step_q   <= step_d;
    end
  end

  assign nxt_idx = iDir ? (idx_q - 3'd1) : (idx_q + 3'd1);
  assign busy    = (state_q != S_IDLE) && (state_q != S_FAULT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hipl_d   = hipl_q;
    hipr_d   = hipr_q;
    stop_d   = stop_q | (busy & iStop);
    homing_d = homing_q;
    step_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          stop_d  = iStop;
          hipl_d  = scale_angle(gait_l(idx_q), iAmp);
          hipr_d  = scale_angle(gait_r(idx_q), iAmp);
          cnt_d   = '0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (iDone == 2'b11) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          // Homing is checked first so a late stop cannot re-trigger homing.
          if (homing_q) begin
            homing_d = 1'b0;
            stop_d   = 1'b0;
            state_d  = S_IDLE;
          end else if (stop_q) begin
            hipl_d   = HOME_DEG;
            hipr_d   = HOME_DEG;
            homing_d = 1'b1;
            state_d  = S_HOLDOFF;
          end else begin
            idx_d   = nxt_idx;
            hipl_d  = scale_angle(gait_l(nxt_idx), iAmp);
            hipr_d  = scale_angle(gait_r(nxt_idx), iAmp);
            step_d  = 1'b1;
            state_d = S_HOLDOFF;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FAULT: begin
        if (iStart) begin
          stop_d   = 1'b0;
          homing_d = 1'b1;
          hipl_d   = HOME_DEG;
          hipr_d   = HOME_DEG;
          cnt_d    = '0;
          state_d  = S_HOLDOFF;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    oBusy      = busy;
    oFault     = (state_q == S_FAULT);
    oStepPulse = step_q;
    oHipL      = hipl_q;
    oHipR      = hipr_q;
    oPoseIdx   = idx_q;
  end

endmodule
